// File: rtl/foo_handshake_merge_if.sv
// Handshake bundle for foo_handshake_merge: three ready/valid sources and the merged output channel.
// The merge block uses the slave modport; sources and sink use master.
interface foo_handshake_merge_if #(
    parameter int WIDTH = 5
);
    logic             handshake_arr_0_valid;
    logic             handshake_arr_0_ready;
    logic [WIDTH-1:0] handshake_arr_0_data;
    logic             handshake_arr_1_valid;
    logic             handshake_arr_1_ready;
    logic [WIDTH-1:0] handshake_arr_1_data;
    logic             handshake_arr_2_valid;
    logic             handshake_arr_2_ready;
    logic [WIDTH-1:0] handshake_arr_2_data;

    logic             handshake_valid;
    logic             handshake_ready;
    logic [WIDTH-1:0] handshake_data;
    logic [1:0]       handshake_src;

    modport master (
        output handshake_arr_0_valid, handshake_arr_0_data,
        output handshake_arr_1_valid, handshake_arr_1_data,
        output handshake_arr_2_valid, handshake_arr_2_data,
        input  handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
        input  handshake_valid, handshake_data, handshake_src,
        output handshake_ready
    );

    modport slave (
        input  handshake_arr_0_valid, handshake_arr_0_data,
        input  handshake_arr_1_valid, handshake_arr_1_data,
        input  handshake_arr_2_valid, handshake_arr_2_data,
        output handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
        output handshake_valid, handshake_data, handshake_src,
        input  handshake_ready
    );
endinterface

// File: rtl/foo_handshake_merge.sv
// Round-robin 3:1 ready/valid merge into a 2-entry output buffer that carries each word's source ID.
// Input readies depend only on registered occupancy, never on the downstream ready.
module foo_handshake_merge #(
    parameter int WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    foo_handshake_merge_if.slave  hs,
    output logic [7:0]            xfer_count
);

    logic [1:0]       count;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [2:0]       valid_vec;
    logic             any_valid;
    logic             can_accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] data_q [2];
    logic [1:0]       src_q  [2];

    always_comb begin
        valid_vec  = {hs.handshake_arr_2_valid, hs.handshake_arr_1_valid, hs.handshake_arr_0_valid};
        any_valid  = |valid_vec;
        can_accept = (count < 2'd2) && !RESET;
        push       = any_valid && can_accept;
        pop        = (count != 2'd0) && hs.handshake_ready;
    end

    // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first valid source.
    always_comb begin
        logic [2:0] sum;
        logic       found;
        winner = 2'd0;
        sum    = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, ptr} + 3'(k);
            if (sum > 3'd2) sum = sum - 3'd3;
            if (!found && valid_vec[sum[1:0]]) begin
                winner = sum[1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (winner)
            2'd1:    win_data = hs.handshake_arr_1_data;
            2'd2:    win_data = hs.handshake_arr_2_data;
            default: win_data = hs.handshake_arr_0_data;
        endcase
        hs.handshake_arr_0_ready = push && (winner == 2'd0);
        hs.handshake_arr_1_ready = push && (winner == 2'd1);
        hs.handshake_arr_2_ready = push && (winner == 2'd2);
        hs.handshake_valid       = (count != 2'd0);
        hs.handshake_data        = data_q[0];
        hs.handshake_src         = src_q[0];
    end

    // Entry 0 is the head; it is only overwritten by a push into an empty
    // slot or by a shift, so the head holds its last value when drained.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count      <= 2'd0;
            ptr        <= 2'd0;
            xfer_count <= 8'd0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            src_q[0]   <= 2'd0;
            src_q[1]   <= 2'd0;
        end else begin
            if (push) begin
                ptr <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
            end
            if (pop) begin
                xfer_count <= xfer_count + 8'd1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data_q[0] <= win_data;
                        src_q[0]  <= winner;
                    end else begin
                        data_q[1] <= win_data;
                        src_q[1]  <= winner;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        data_q[0] <= data_q[1];
                        src_q[0]  <= src_q[1];
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    data_q[0] <= win_data;
                    src_q[0]  <= winner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_foo_handshake_merge.sv
// Directed self-checking bench for foo_handshake_merge with hand-computed expectations.
module tb_foo_handshake_merge;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] xfer_count;
    logic [2:0] rdy_vec;
    int         compared = 0;
    int         mismatched = 0;

    always #5 CLK = ~CLK;

    foo_handshake_merge_if #(.WIDTH(5)) hs ();

    foo_handshake_merge #(.WIDTH(5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .hs         (hs),
        .xfer_count (xfer_count)
    );

    assign rdy_vec = {hs.handshake_arr_2_ready, hs.handshake_arr_1_ready, hs.handshake_arr_0_ready};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                                 input logic [4:0] d2, input logic rdy);
        hs.handshake_arr_0_valid = v[0];
        hs.handshake_arr_1_valid = v[1];
        hs.handshake_arr_2_valid = v[2];
        hs.handshake_arr_0_data  = d0;
        hs.handshake_arr_1_data  = d1;
        hs.handshake_arr_2_data  = d2;
        hs.handshake_ready       = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        // Power-up reset with all sources requesting: no ready may rise.
        RESET = 1'b1;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
        checkOutput("ready_in_reset", rdy_vec, 3'b000);
        tick();
        tick();
        checkOutput("rst_valid", hs.handshake_valid, 0);
        checkOutput("rst_data", hs.handshake_data, 0);
        checkOutput("rst_src", hs.handshake_src, 0);
        checkOutput("rst_xfer", xfer_count, 0);
        RESET = 1'b0;

        // Single word from source 1.
        applyStimulus(3'b010, 5'd0, 5'h0A, 5'd0, 1'b1);
        checkOutput("a_ready", rdy_vec, 3'b010);
        tick();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("a_valid", hs.handshake_valid, 1);
        checkOutput("a_data", hs.handshake_data, 5'h0A);
        checkOutput("a_src", hs.handshake_src, 1);
        tick();
        checkOutput("a_xfer", xfer_count, 1);
        checkOutput("a_empty", hs.handshake_valid, 0);
        checkOutput("a_hold_data", hs.handshake_data, 5'h0A);

        // Fairness with all three sources continuously valid.
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
            checkOutput("b_ready", rdy_vec, 3'b001 << (k % 3));
            tick();
            checkOutput("b_src", hs.handshake_src, k % 3);
            checkOutput("b_data", hs.handshake_data, (k % 3) + 1);
        end
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        checkOutput("b_xfer", xfer_count, 6);
        checkOutput("b_empty", hs.handshake_valid, 0);

        // Backpressure: fill to two entries, hold, then drain in order.
        doReset();
        applyStimulus(3'b101, 5'h11, 5'd0, 5'h13, 1'b0);
        checkOutput("c_ready0", rdy_vec, 3'b001);
        tick();
        applyStimulus(3'b101, 5'h11, 5'd0, 5'h13, 1'b0);
        checkOutput("c_ready2", rdy_vec, 3'b100);
        tick();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(3'b101, 5'h11, 5'd0, 5'h13, 1'b0);
            checkOutput("c_full_ready", rdy_vec, 3'b000);
            checkOutput("c_hold_data", hs.handshake_data, 5'h11);
            checkOutput("c_hold_src", hs.handshake_src, 0);
            tick();
        end
        applyStimulus(3'b101, 5'h11, 5'd0, 5'h13, 1'b1);
        checkOutput("c_full_rdy1", rdy_vec, 3'b000);
        tick();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("c_second_valid", hs.handshake_valid, 1);
        checkOutput("c_second_data", hs.handshake_data, 5'h13);
        checkOutput("c_second_src", hs.handshake_src, 2);
        tick();
        checkOutput("c_drained", hs.handshake_valid, 0);
        checkOutput("c_xfer", xfer_count, 2);

        // Steady state at one entry: push and pop every cycle.
        doReset();
        for (int k = 0; k < 21; k++) begin
            applyStimulus(3'b001, 5'(k + 5), 5'd0, 5'd0, 1'b1);
            checkOutput("d_ready", rdy_vec, 3'b001);
            tick();
            checkOutput("d_valid", hs.handshake_valid, 1);
            checkOutput("d_data", hs.handshake_data, k + 5);
        end
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        checkOutput("d_xfer", xfer_count, 21);
        checkOutput("d_empty", hs.handshake_valid, 0);

        // Build up count=2 with xfer_count=37, then reset mid-operation.
        for (int k = 0; k < 17; k++) begin
            applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 1'b1);
            tick();
        end
        applyStimulus(3'b001, 5'd8, 5'd0, 5'd0, 1'b0);
        tick();
        checkOutput("e_xfer37", xfer_count, 37);
        checkOutput("e_valid_pre", hs.handshake_valid, 1);
        RESET = 1'b1;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
        checkOutput("e_ready_in_reset", rdy_vec, 3'b000);
        tick();
        RESET = 1'b0;
        checkOutput("e_valid", hs.handshake_valid, 0);
        checkOutput("e_xfer", xfer_count, 0);
        checkOutput("e_data", hs.handshake_data, 0);
        checkOutput("e_src", hs.handshake_src, 0);
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 1'b1);
        checkOutput("e_first_grant", rdy_vec, 3'b001);
        tick();
        checkOutput("e_first_src", hs.handshake_src, 0);

        // xfer_count wrap over 256 pops.
        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'b001, 5'(i), 5'd0, 5'd0, 1'b1);
            tick();
            if (i == 128) checkOutput("f_xfer128", xfer_count, 128);
        end
        checkOutput("f_xfer255", xfer_count, 255);
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        checkOutput("f_xfer_wrap", xfer_count, 0);
        checkOutput("f_empty", hs.handshake_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
